// File: rtl/stonyman_apb3_mc.sv
// stonyman_apb3_mc: APB3 slave bridging the fabric bus to N Stonyman
// pixel-capture channels. Provides a status view of every channel's FIFO
// flags, per-channel start-capture strobes with acknowledge timeout, a
// channel-select register, a latency-aware FIFO pop sequencer and a pop
// counter.
module stonyman_apb3_mc #(
  parameter int         N_CH        = 2,
  parameter int         PIX_W       = 8,
  parameter int         FIFO_RD_LAT = 2,
  parameter int         ACK_TIMEOUT = 1024,
  parameter logic [7:0] ADDR_MASK   = 8'hFF
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic [N_CH-1:0]        FULL,
  input  logic [N_CH-1:0]        EMPTY,
  input  logic [N_CH-1:0]        BUSY,
  output logic [N_CH-1:0]        RDEN,
  input  logic [N_CH*PIX_W-1:0]  PIXELSIN,
  output logic [N_CH-1:0]        START_CAPTURE
);

  localparam int              TMR_W     = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  // WAIT covers the latency cycles left after the strobe cycle itself
  localparam logic [2:0]      WAIT_LAST = (FIFO_RD_LAT > 1) ? 3'(FIFO_RD_LAT - 2) : 3'd0;
  localparam logic [3:0]      N_CH_4    = 4'(N_CH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h04;
  localparam logic [7:0] OFF_CHSEL  = 8'h08;
  localparam logic [7:0] OFF_DATA   = 8'h0C;
  localparam logic [7:0] OFF_POPCNT = 8'h10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_DONE
  } pop_state_e;

  pop_state_e                  state_q, state_d;
  logic [2:0]                  wcnt_q, wcnt_d;
  logic [2:0]                  pop_ch_q, pop_ch_d;
  logic [2:0]                  chsel_q, chsel_d;
  logic [31:0]                 popcnt_q, popcnt_d;
  logic [PIX_W-1:0]            data_q, data_d;
  logic                        rsp_q, rsp_d;
  logic                        abort_q, abort_d;
  logic [N_CH-1:0]             pend_q, pend_d;
  logic [N_CH-1:0]             flag_q, flag_d;
  logic [N_CH-1:0][TMR_W-1:0]  timer_q, timer_d;

  logic [7:0]       offset;
  logic             access;
  logic             rd_data_req;
  logic             chsel_bad;
  logic             wr_en;
  logic             empty_sel;
  logic [PIX_W-1:0] pix_sel;
  logic             unused_bits;

  assign offset      = PADDR[7:0] & ADDR_MASK;
  assign access      = PSEL & PENABLE;
  assign rd_data_req = access & ~PWRITE & (offset == OFF_DATA);
  assign chsel_bad   = ({1'b0, PWDATA[2:0]} >= N_CH_4);
  assign unused_bits = ^{PADDR[31:8], PWDATA};

  // Only DATA reads that must pop stall; a pending pop response completes at once
  assign PREADY  = access & (state_q == S_IDLE) & (rsp_q | ~rd_data_req | empty_sel);
  assign PSLVERR = PREADY & ((PWRITE & (offset == OFF_CHSEL) & chsel_bad) |
                             (rd_data_req & ~rsp_q & empty_sel));
  assign wr_en   = PREADY & PWRITE;

  assign START_CAPTURE = ~pend_q;

  // Pick the EMPTY flag of the selected channel and the pixel of the popping one
  always_comb begin
    empty_sel = 1'b1;
    pix_sel   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (chsel_q == 3'(c)) empty_sel = EMPTY[c];
      if (pop_ch_q == 3'(c)) pix_sel = PIXELSIN[c*PIX_W +: PIX_W];
    end
  end

  // Single active-low read strobe, asserted only in POP for the latched channel
  always_comb begin
    RDEN = '1;
    for (int c = 0; c < N_CH; c++) begin
      if ((state_q == S_POP) && (pop_ch_q == 3'(c))) RDEN[c] = 1'b0;
    end
  end

  // Read-data mux; zero outside read access phases
  always_comb begin
    PRDATA = '0;
    if (access & ~PWRITE) begin
      case (offset)
        OFF_STATUS: begin
          for (int c = 0; c < N_CH; c++) begin
            PRDATA[3*c +: 3] = {BUSY[c], EMPTY[c], FULL[c]};
            PRDATA[24+c]     = flag_q[c];
          end
        end
        OFF_CTRL:   PRDATA = 32'(pend_q);
        OFF_CHSEL:  PRDATA = {29'd0, chsel_q};
        OFF_DATA:   PRDATA = rsp_q ? 32'(data_q) : 32'd0;
        OFF_POPCNT: PRDATA = popcnt_q;
        default:    PRDATA = '0;
      endcase
    end
  end

  // Pop sequencer next state, channel select and pop counter
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pop_ch_d = pop_ch_q;
    data_d   = data_q;
    popcnt_d = popcnt_q;
    chsel_d  = chsel_q;
    rsp_d    = 1'b0;
    abort_d  = abort_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (rd_data_req & ~rsp_q & ~empty_sel) begin
          state_d  = S_POP;
          pop_ch_d = chsel_q;
        end
      end
      S_POP: begin
        wcnt_d  = 3'd0;
        state_d = (FIFO_RD_LAT > 1) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = S_DONE;
        else                     wcnt_d  = wcnt_q + 3'd1;
      end
      S_DONE: begin
        data_d   = pix_sel;
        popcnt_d = popcnt_q + 32'd1;
        state_d  = S_IDLE;
        // A master that let go mid-pop gets no completion
        rsp_d    = PSEL & ~abort_q;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && ~PSEL) abort_d = 1'b1;

    if (wr_en && (offset == OFF_CHSEL) && !chsel_bad) chsel_d = PWDATA[2:0];
    if (wr_en && (offset == OFF_POPCNT)) popcnt_d = '0;
  end

  // Start-capture handshake with acknowledge timeout, per channel
  always_comb begin
    pend_d  = pend_q;
    flag_d  = flag_q;
    timer_d = timer_q;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en && (offset == OFF_CTRL) && PWDATA[24+c]) flag_d[c] = 1'b0;
      if (pend_q[c]) begin
        if (BUSY[c]) begin
          pend_d[c] = 1'b0;
        end else if (timer_q[c] == TMR_LAST) begin
          // Set wins over a same-cycle clear
          pend_d[c] = 1'b0;
          flag_d[c] = 1'b1;
        end else begin
          timer_d[c] = timer_q[c] + TMR_W'(1);
        end
      end else if (wr_en && (offset == OFF_CTRL) && PWDATA[c]) begin
        pend_d[c]  = 1'b1;
        timer_d[c] = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      pop_ch_q <= '0;
      chsel_q  <= '0;
      popcnt_q <= '0;
      data_q   <= '0;
      rsp_q    <= 1'b0;
      abort_q  <= 1'b0;
      pend_q   <= '0;
      flag_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pop_ch_q <= pop_ch_d;
      chsel_q  <= chsel_d;
      popcnt_q <= popcnt_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
      abort_q  <= abort_d;
      pend_q   <= pend_d;
      flag_q   <= flag_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_stonyman_apb3_mc.sv
// Scoreboard bench for stonyman_apb3_mc (N_CH=2, PIX_W=8, FIFO_RD_LAT=2,
// ACK_TIMEOUT=1024). Stimulus queues the expected APB completion; a negedge
// monitor compares each completion against the queue head.
module tb_stonyman_apb3_mc;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  FULL = 2'b00, EMPTY = 2'b11, BUSY = 2'b00;
  logic [1:0]  RDEN, START_CAPTURE;
  logic [15:0] PIXELSIN;
  logic [7:0]  pix0 = 8'h00, pix1 = 8'h00;
  logic [1:0]  d1 = 2'b00, d2 = 2'b00;

  stonyman_apb3_mc #(
    .N_CH(2), .PIX_W(8), .FIFO_RD_LAT(2), .ACK_TIMEOUT(1024), .ADDR_MASK(8'hFF)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .RDEN(RDEN), .PIXELSIN(PIXELSIN),
    .START_CAPTURE(START_CAPTURE)
  );

  always #5 PCLK = ~PCLK;

  // FIFO model: data valid exactly two cycles after the strobe cycle, junk otherwise
  always @(posedge PCLK) begin
    d1 <= ~RDEN;
    d2 <= d1;
  end
  assign PIXELSIN = {(d2[1] ? pix1 : 8'hEE), (d2[0] ? pix0 : 8'hEE)};

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
    string       nm;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_m;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wcnt = 0;
  int         rden_lo = 0;
  logic [1:0] rden_seen = 2'b11;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: strobe sanity and APB completions against the scoreboard
  always @(negedge PCLK) begin
    if (RDEN != 2'b11) begin
      rden_lo++;
      rden_seen = RDEN;
      check("rden_single_low", 32'($countones(~RDEN)), 32'd1);
    end
    if (PSEL && PENABLE) begin
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pready: got PREADY=1 want no completion");
        end else begin
          e_m = exp_q.pop_front();
          check({e_m.nm, "_prdata"}, PRDATA, e_m.rd);
          check({e_m.nm, "_pslverr"}, 32'(PSLVERR), 32'(e_m.err));
          check({e_m.nm, "_waits"}, 32'(wcnt), 32'(e_m.waits));
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_w,
                     input string nm);
    int n;
    exp_q.push_back('{exp_rd, exp_err, exp_w, nm});
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    @(negedge PCLK);
    while (!PREADY && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    if (!PREADY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no PREADY in 40 cycles want completion", nm);
      void'(exp_q.pop_back());
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err,
                    input int exp_w, input string nm);
    apb(1'b0, addr, 32'd0, exp_rd, exp_err, exp_w, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                    input string nm);
    apb(1'b1, addr, wdata, 32'd0, exp_err, 0, nm);
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_rden", 32'(RDEN), 32'h3);
    check("reset_start", 32'(START_CAPTURE), 32'h3);
    PRESET = 1'b0;

    // STATUS layout: {BUSY,EMPTY,FULL} per channel
    FULL = 2'b01; EMPTY = 2'b10; BUSY = 2'b00;
    rd(32'h00, 32'h0000_0011, 1'b0, 0, "status_a");
    FULL = 2'b10; EMPTY = 2'b01; BUSY = 2'b10;
    rd(32'h00, 32'h0000_002A, 1'b0, 0, "status_b");
    FULL = 2'b00; BUSY = 2'b00;
    rd(32'h04, 32'h0, 1'b0, 0, "ctrl_reset");
    rd(32'h08, 32'h0, 1'b0, 0, "chsel_reset");
    rd(32'h10, 32'h0, 1'b0, 0, "popcnt_reset");
    rd(32'h14, 32'h0, 1'b0, 0, "unmapped_rd");
    wr(32'h14, 32'hFFFF_FFFF, 1'b0, "unmapped_wr");

    // Pop from channel 1
    pix0 = 8'h5A; pix1 = 8'hA5; EMPTY = 2'b00;
    wr(32'h08, 32'h1, 1'b0, "chsel_wr1");
    rd(32'h08, 32'h1, 1'b0, 0, "chsel_rd1");
    base = rden_lo;
    rd(32'h0C, 32'h0000_00A5, 1'b0, 4, "pop_ch1");
    check("pop_ch1_strobe_cycles", 32'(rden_lo - base), 32'd1);
    check("pop_ch1_strobe_bits", 32'(rden_seen), 32'h1);
    rd(32'h10, 32'h1, 1'b0, 0, "popcnt_1");

    // Pop from channel 0, POPCNT read through masked-off address bits
    wr(32'h08, 32'h0, 1'b0, "chsel_wr0");
    rd(32'h0C, 32'h0000_005A, 1'b0, 4, "pop_ch0");
    check("pop_ch0_strobe_bits", 32'(rden_seen), 32'h2);
    rd(32'h110, 32'h2, 1'b0, 0, "popcnt_2");

    // Empty FIFO: immediate error, no strobe, no count
    EMPTY = 2'b01;
    base = rden_lo;
    rd(32'h0C, 32'h0, 1'b1, 0, "pop_empty");
    check("pop_empty_no_strobe", 32'(rden_lo - base), 32'd0);
    rd(32'h10, 32'h2, 1'b0, 0, "popcnt_after_empty");
    EMPTY = 2'b00;

    // Out-of-range channel select
    wr(32'h08, 32'h1, 1'b0, "chsel_wr_ok");
    wr(32'h08, 32'h5, 1'b1, "chsel_wr_bad");
    rd(32'h08, 32'h1, 1'b0, 0, "chsel_kept");

    // Start both channels; ack channel 0 late, let channel 1 time out
    wr(32'h04, 32'h3, 1'b0, "ctrl_start");
    check("start_low", 32'(START_CAPTURE), 32'h0);
    n = 0;
    while (START_CAPTURE[1] == 1'b0 && n < 2000) begin
      if (n == 5) begin
        check("start0_before_busy", 32'(START_CAPTURE[0]), 32'h0);
        BUSY = 2'b01;
      end
      if (n == 6) begin
        check("start0_after_busy", 32'(START_CAPTURE[0]), 32'h1);
        BUSY = 2'b00;
      end
      @(posedge PCLK); #1;
      n++;
    end
    check("start1_low_cycles", 32'(n), 32'd1024);
    rd(32'h00, 32'h0200_0000, 1'b0, 0, "status_timeout");
    rd(32'h04, 32'h0, 1'b0, 0, "ctrl_not_pending");
    wr(32'h04, 32'h0200_0000, 1'b0, "ctrl_clr_flag");
    rd(32'h00, 32'h0, 1'b0, 0, "status_cleared");

    // Reset during the WAIT state of a pop on channel 1
    base = rden_lo;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0C;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      check("midpop_reset_rden", 32'(RDEN), 32'h3);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    check("midpop_strobe_cycles", 32'(rden_lo - base), 32'd1);
    rd(32'h10, 32'h0, 1'b0, 0, "popcnt_after_reset");
    rd(32'h08, 32'h0, 1'b0, 0, "chsel_after_reset");
    rd(32'h0C, 32'h0000_005A, 1'b0, 4, "pop_after_reset");
    rd(32'h10, 32'h1, 1'b0, 0, "popcnt_after_pop");

    repeat (3) @(posedge PCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
